frame_rmw_sequencer: RTL and testbench

FRAME_RMW_SEQUENCER -- requirements
Module: frame_rmw_sequencer

---
 rtl/frame_pkg.sv | 17 +
 rtl/pixel_op.sv | 27 ++
 rtl/frame_rmw_sequencer.sv | 157 +++++++++++++++
 tb/tb_frame_rmw_sequencer.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_pkg.sv
// Shared state encoding and pixel-op codes for the frame sequencing blocks.
package frame_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StWait,
    StWrite,
    StDone
  } frame_state_e;

  localparam logic [1:0] ModeCopy   = 2'd0;
  localparam logic [1:0] ModeInvert = 2'd1;
  localparam logic [1:0] ModeThresh = 2'd2;
  localparam logic [1:0] ModeAdd    = 2'd3;

endpackage

// File: rtl/pixel_op.sv
// Combinational per-pixel transform: copy, invert, threshold or saturating add.
module pixel_op
  import frame_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] param,
  input  logic [DATA_W-1:0] p,
  output logic [DATA_W-1:0] result
);

  logic [DATA_W:0] sum;

  always_comb begin
    sum    = {1'b0, p} + {1'b0, param};
    result = p;
    case (mode)
      ModeCopy:   result = p;
      ModeInvert: result = ~p;
      ModeThresh: result = (p >= param) ? '1 : '0;
      ModeAdd:    result = sum[DATA_W] ? '1 : sum[DATA_W-1:0];
      default:    result = p;
    endcase
  end

endmodule

// File: rtl/frame_rmw_sequencer.sv
// Walks a frame in raster order, reading each source pixel, transforming it and
// writing it to the destination buffer through a single-port RAM interface.
module frame_rmw_sequencer
  import frame_pkg::*;
#(
  parameter int unsigned IMG_W  = 28,
  parameter int unsigned IMG_H  = 28,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] param,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done
);

  localparam int unsigned       XW        = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned       YW        = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [XW-1:0]     XLast     = XW'(IMG_W - 1);
  localparam logic [YW-1:0]     YLast     = YW'(IMG_H - 1);
  localparam logic [ADDR_W-1:0] RowStride = ADDR_W'(IMG_W);
  localparam logic [1:0]        WaitLast  = 2'(RD_LAT - 1);

  frame_state_e      state_q, state_d;
  logic [XW-1:0]     x_q, x_d;
  logic [YW-1:0]     y_q, y_d;
  logic [1:0]        wcnt_q, wcnt_d;
  logic [DATA_W-1:0] pix_q, pix_d;
  logic [1:0]        mode_q, mode_d;
  logic [DATA_W-1:0] param_q, param_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;

  logic [ADDR_W-1:0] pix_off;
  logic [DATA_W-1:0] op_result;

  // Address arithmetic wraps naturally at ADDR_W bits.
  assign pix_off = ADDR_W'(y_q) * RowStride + ADDR_W'(x_q);

  pixel_op #(
    .DATA_W(DATA_W)
  ) u_pixel_op (
    .mode  (mode_q),
    .param (param_q),
    .p     (pix_q),
    .result(op_result)
  );

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q <= StIdle;
      x_q     <= '0;
      y_q     <= '0;
      wcnt_q  <= '0;
      pix_q   <= '0;
      mode_q  <= '0;
      param_q <= '0;
      src_q   <= '0;
      dst_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      wcnt_q  <= wcnt_d;
      pix_q   <= pix_d;
      mode_q  <= mode_d;
      param_q <= param_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    wcnt_d    = wcnt_q;
    pix_d     = pix_q;
    mode_d    = mode_q;
    param_d   = param_q;
    src_d     = src_q;
    dst_d     = dst_q;
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    busy      = (state_q != StIdle);
    done      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start && !abort) begin
          mode_d  = mode;
          param_d = param;
          src_d   = src_base;
          dst_d   = dst_base;
          x_d     = '0;
          y_d     = '0;
          state_d = StRead;
        end
      end
      StRead: begin
        mem_addr = src_q + pix_off;
        wcnt_d   = '0;
        state_d  = StWait;
      end
      StWait: begin
        // Hold the source address so pipelined RAMs see a stable request.
        mem_addr = src_q + pix_off;
        if (wcnt_q == WaitLast) begin
          pix_d   = mem_rdata;
          state_d = StWrite;
        end else begin
          wcnt_d = wcnt_q + 2'd1;
        end
      end
      StWrite: begin
        mem_we    = 1'b1;
        mem_addr  = dst_q + pix_off;
        mem_wdata = op_result;
        if (x_q != XLast) begin
          x_d     = x_q + 1'b1;
          state_d = StRead;
        end else if (y_q != YLast) begin
          x_d     = '0;
          y_d     = y_q + 1'b1;
          state_d = StRead;
        end else begin
          state_d = StDone;
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Abort overrides everything: no write, no completion pulse.
    if (abort && (state_q != StIdle)) begin
      state_d = StIdle;
      mem_we  = 1'b0;
      done    = 1'b0;
    end
  end

endmodule

// File: tb/tb_frame_rmw_sequencer.sv
// Scoreboard bench: a raster-order reference model predicts every write and
// the done pulse; a negedge monitor pops and compares what the DUT emits.
module tb_frame_rmw_sequencer;

  localparam int W    = 5;
  localparam int H    = 3;
  localparam int L    = 3;
  localparam int DW   = 8;
  localparam int AW   = 16;
  localparam int NPIX = W * H;
  localparam int PC   = L + 2;
  localparam int MAXV = (1 << DW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [1:0]    mode = '0;
  logic [DW-1:0] param = '0;
  logic [AW-1:0] src_base = '0;
  logic [AW-1:0] dst_base = '0;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  frame_rmw_sequencer #(
    .IMG_W (W),
    .IMG_H (H),
    .DATA_W(DW),
    .ADDR_W(AW),
    .RD_LAT(L)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .mode     (mode),
    .param    (param),
    .src_base (src_base),
    .dst_base (dst_base),
    .mem_addr (mem_addr),
    .mem_we   (mem_we),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .busy     (busy),
    .done     (done)
  );

  // RAM: unwritten cells read as (address mod 256); read data appears L cycles later.
  logic [DW-1:0] ram     [0:65535];
  logic          ram_vld [0:65535];
  logic [DW-1:0] rd_pipe [0:L-1];
  logic          mem_clr = 1'b1;

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 65536; i++) ram_vld[i] <= 1'b0;
    end else if (mem_we) begin
      ram[mem_addr]     <= mem_wdata;
      ram_vld[mem_addr] <= 1'b1;
    end
    rd_pipe[0] <= ram_vld[mem_addr] ? ram[mem_addr] : mem_addr[DW-1:0];
    for (int i = 1; i < L; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_rdata = rd_pipe[L-1];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int addr;
    int data;
    int cyc;
  } wr_t;

  wr_t  exp_wr[$];
  int   exp_done[$];
  int   ref_mem [0:65535];
  int   n_tests = 0;
  int   n_fail = 0;
  logic mon_en = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h), cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  function automatic int ref_op(input int m, input int prm, input int p);
    case (m)
      0:       return p;
      1:       return MAXV - p;
      2:       return (p >= prm) ? MAXV : 0;
      default: return (p + prm > MAXV) ? MAXV : p + prm;
    endcase
  endfunction

  always @(negedge clk) begin
    wr_t e;
    if (mon_en) begin
      if (mem_we) begin
        if (exp_wr.size() == 0) begin
          check("unexpected_write", 1, 0);
        end else begin
          e = exp_wr.pop_front();
          check("wr_addr", int'(mem_addr), e.addr);
          check("wr_data", int'(mem_wdata), e.data);
          check("wr_cycle", cyc, e.cyc);
        end
      end
      if (done) begin
        if (exp_done.size() == 0) check("unexpected_done", 1, 0);
        else check("done_cycle", cyc, exp_done.pop_front());
      end
    end
  end

  // Issue a frame; the model predicts the first 'keep' pixels in raster order.
  task automatic issue(input int m, input int prm, input int src, input int dst,
                       input int keep, input bit want_done, output int c);
    wr_t e;
    int  sa;
    @(posedge clk);
    #1;
    c        = cyc;
    mode     = 2'(m);
    param    = DW'(prm);
    src_base = AW'(src);
    dst_base = AW'(dst);
    start    = 1'b1;
    for (int k = 0; k < keep; k++) begin
      sa     = (src + k) & 16'hFFFF;
      e.addr = (dst + k) & 16'hFFFF;
      e.data = ref_op(m, prm, ref_mem[sa]);
      e.cyc  = c + (k + 1) * PC;
      ref_mem[e.addr] = e.data;
      exp_wr.push_back(e);
    end
    if (want_done) exp_done.push_back(c + NPIX * PC + 1);
    @(posedge clk);
    #1;
    start    = 1'b0;
    mode     = 2'($urandom);
    param    = DW'($urandom);
    src_base = AW'($urandom);
    dst_base = AW'($urandom);
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_wr.size() != 0 || exp_done.size() != 0) && n < 400) begin
      @(posedge clk);
      n++;
    end
    check("drain_pending", exp_wr.size() + exp_done.size(), 0);
    exp_wr.delete();
    exp_done.delete();
    repeat (3) @(posedge clk);
    #1;
    check("idle_after", int'(busy), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    int c;
    for (int i = 0; i < 65536; i++) ref_mem[i] = i % 256;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n   = 1'b0;
    mem_clr = 1'b0;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_we", int'(mem_we), 0);
    check("rst_addr", int'(mem_addr), 0);
    check("rst_wdata", int'(mem_wdata), 0);
    mon_en = 1'b1;

    // Plain copy, then each op on pixels that exercise its corner cases.
    issue(0, 0, 16'h0000, 16'h0400, NPIX, 1'b1, c);
    drain();
    issue(1, 0, 16'h003C, 16'h8100, NPIX, 1'b1, c);
    drain();
    issue(2, 8'h80, 16'h007F, 16'h8200, NPIX, 1'b1, c);
    drain();
    issue(3, 8'h10, 16'h00F5, 16'h8300, NPIX, 1'b1, c);
    drain();
    issue(3, 8'h10, 16'h0020, 16'h8400, NPIX, 1'b1, c);
    drain();

    // Source wraps past 0xFFFF; a second start mid-frame must be ignored.
    issue(0, 0, 16'hFFFE, 16'h8500, NPIX, 1'b1, c);
    wait_until(c + 7);
    start    = 1'b1;
    mode     = 2'd1;
    src_base = 16'h1234;
    dst_base = 16'h9000;
    @(posedge clk);
    #1;
    start = 1'b0;
    drain();

    // Abort during the 10th pixel's wait: nine writes, no done.
    issue(2, 8'h40, 16'h0100, 16'h8600, 9, 1'b0, c);
    wait_until(c + 1 + 9 * PC + 2);
    check("busy_pre_abort", int'(busy), 1);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    check("busy_post_abort", int'(busy), 0);
    check("we_post_abort", int'(mem_we), 0);
    drain();
    issue(3, 8'hC0, 16'h0180, 16'h8700, NPIX, 1'b1, c);
    drain();

    // Abort and start together in idle: nothing starts.
    @(posedge clk);
    #1;
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    check("busy_abort_start", int'(busy), 0);
    repeat (20) @(posedge clk);
    #1;
    check("busy_abort_later", int'(busy), 0);

    // Reset mid-frame abandons the frame.
    issue(1, 0, 16'h0140, 16'h8800, 3, 1'b0, c);
    wait_until(c + 1 + 3 * PC + 1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    check("busy_post_reset", int'(busy), 0);
    check("addr_post_reset", int'(mem_addr), 0);
    check("we_post_reset", int'(mem_we), 0);
    drain();
    issue(0, 0, 16'h01A0, 16'h8900, NPIX, 1'b1, c);
    drain();

    for (int t = 0; t < 6; t++) begin
      issue(int'($urandom_range(0, 3)), int'($urandom_range(0, 255)),
            int'($urandom_range(0, 16'h7FFF)), int'($urandom_range(16'h8000, 16'hFFFF)),
            NPIX, 1'b1, c);
      drain();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
